// File: rtl/mem_addr_gen.sv
// Three-stage SRAM address generator: S1 accepts and multiplies, S2 folds,
// range-checks and issues an active-low read, S3 holds sideband aligned with rdata.
module mem_addr_gen #(
  parameter int NUM_MEM    = 3,
  parameter int ADDR_W     = 10,
  parameter int ROW_W      = 6,
  parameter int COL_W      = 10,
  parameter int DATA_W     = 16,
  parameter int TAG_W      = 6,
  parameter int MEM_DEPTH  = 1024,
  parameter int HASH_SHIFT = 4,
  localparam int SEL_W     = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_hash,
  input  logic [ROW_W-1:0]          in_row,
  input  logic [COL_W-1:0]          in_col_dim,
  input  logic [COL_W-1:0]          in_col_idx,
  input  logic [ADDR_W-1:0]         in_offset,
  input  logic [DATA_W-1:0]         in_value,
  input  logic [TAG_W-1:0]          in_tag,
  output logic [NUM_MEM-1:0]        mem_cen,
  output logic [NUM_MEM-1:0]        mem_wen,
  output logic [NUM_MEM*ADDR_W-1:0] mem_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_sel,
  output logic [DATA_W-1:0]         out_value,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      out_err,
  input  logic                      err_clr,
  output logic                      err_sticky
);
  localparam int LIN_W = ROW_W + COL_W;
  localparam int SUM_W = LIN_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_L = SUM_W'(MEM_DEPTH);
  localparam logic [SEL_W:0]   NMEM_L  = (SEL_W + 1)'(NUM_MEM);

  // Handshake: a beat transfers on the rising edge where valid & ready are both
  // high; valid never depends on ready, and ready may depend on downstream ready.

  logic              s1_valid, s1_hash;
  logic [SEL_W-1:0]  s1_sel;
  logic [LIN_W-1:0]  s1_lin;
  logic [COL_W-1:0]  s1_col_idx;
  logic [ADDR_W-1:0] s1_offset;
  logic [DATA_W-1:0] s1_value;
  logic [TAG_W-1:0]  s1_tag;

  logic              s2_valid, s2_err;
  logic [SEL_W-1:0]  s2_sel;
  logic [ADDR_W-1:0] s2_addr;
  logic [DATA_W-1:0] s2_value;
  logic [TAG_W-1:0]  s2_tag;

  logic [LIN_W-1:0]  lin_full, lin_f;
  logic [SUM_W-1:0]  sum;
  logic              s1_err;
  logic              issue, load_s2;

  assign lin_full = s1_lin + LIN_W'(s1_col_idx);
  assign lin_f    = s1_hash ? (lin_full ^ (lin_full >> HASH_SHIFT)) : lin_full;
  assign sum      = SUM_W'(s1_offset) + SUM_W'(lin_f);
  assign s1_err   = (sum >= DEPTH_L) || ({1'b0, s1_sel} >= NMEM_L);

  // A read is only launched when S3 is free to take its data; rst kills it outright.
  assign issue    = s2_valid && (!out_valid || out_ready) && !rst;
  assign load_s2  = !s2_valid || issue;
  assign in_ready = !s1_valid || !s2_valid || issue;
  assign mem_wen  = '1;

  always_comb begin
    mem_cen  = '1;
    mem_addr = '0;
    for (int i = 0; i < NUM_MEM; i++) begin
      if (issue && !s2_err && (s2_sel == SEL_W'(i))) begin
        mem_cen[i]                   = 1'b0;
        mem_addr[i*ADDR_W +: ADDR_W] = s2_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_hash    <= 1'b0;
      s1_sel     <= '0;
      s1_lin     <= '0;
      s1_col_idx <= '0;
      s1_offset  <= '0;
      s1_value   <= '0;
      s1_tag     <= '0;
      s2_valid   <= 1'b0;
      s2_err     <= 1'b0;
      s2_sel     <= '0;
      s2_addr    <= '0;
      s2_value   <= '0;
      s2_tag     <= '0;
      out_valid  <= 1'b0;
      out_sel    <= '0;
      out_value  <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        s1_valid   <= 1'b1;
        s1_hash    <= in_hash;
        s1_sel     <= in_sel;
        s1_lin     <= LIN_W'(in_row) * LIN_W'(in_col_dim);
        s1_col_idx <= in_col_idx;
        s1_offset  <= in_offset;
        s1_value   <= in_value;
        s1_tag     <= in_tag;
      end else if (load_s2) begin
        s1_valid <= 1'b0;
      end

      if (load_s2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_err   <= s1_err;
          s2_sel   <= s1_sel;
          s2_addr  <= sum[ADDR_W-1:0];
          s2_value <= s1_value;
          s2_tag   <= s1_tag;
        end
      end

      if (issue) begin
        out_valid <= 1'b1;
        out_sel   <= s2_sel;
        out_value <= s2_value;
        out_tag   <= s2_tag;
        out_err   <= s2_err;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // Setting wins over a simultaneous clear so no rejection is ever lost.
      if (issue && s2_err) begin
        err_sticky <= 1'b1;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_addr_gen.sv
// Directed bench for mem_addr_gen: vector table, cen/output scoreboards and
// hand-written latency, sticky, backpressure, reset and streaming sequences.
module tb_mem_addr_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_hash;
  logic [1:0]  in_sel;
  logic [5:0]  in_row;
  logic [9:0]  in_col_dim, in_col_idx, in_offset;
  logic [15:0] in_value;
  logic [5:0]  in_tag;
  logic [2:0]  mem_cen, mem_wen;
  logic [29:0] mem_addr;
  logic        out_valid, out_ready, out_err, err_clr, err_sticky;
  logic [1:0]  out_sel;
  logic [15:0] out_value;
  logic [5:0]  out_tag;

  always #5 clk = ~clk;

  mem_addr_gen dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_hash(in_hash), .in_row(in_row),
    .in_col_dim(in_col_dim), .in_col_idx(in_col_idx), .in_offset(in_offset),
    .in_value(in_value), .in_tag(in_tag), .mem_cen(mem_cen), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_value(out_value), .out_tag(out_tag),
    .out_err(out_err), .err_clr(err_clr), .err_sticky(err_sticky)
  );

  typedef struct {
    logic [1:0]  sel;
    logic        hash;
    logic [5:0]  row;
    logic [9:0]  col_dim;
    logic [9:0]  col_idx;
    logic [9:0]  offset;
    logic [15:0] value;
    logic [5:0]  tag;
    logic [9:0]  exp_addr;
    logic        exp_err;
  } vec_t;

  vec_t        tbl[11];
  vec_t        svec[64];
  vec_t        cur_v;
  logic [34:0] exp_q[$];
  logic [11:0] iss_q[$];
  logic [34:0] e_out;
  logic [11:0] e_iss;
  logic [2:0]  exp_cen;
  logic [29:0] exp_bus;
  int          n_tests = 0, n_fail = 0;
  int          pulse_cnt = 0, beat_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] sel, input logic hash, input logic [5:0] row,
                              input logic [9:0] dim, input logic [9:0] idx, input logic [9:0] off,
                              input logic [15:0] value, input logic [5:0] tag);
    vec_t        v;
    logic [15:0] lin;
    logic [15:0] f;
    logic [16:0] s;
    lin = 16'(row) * 16'(dim) + 16'(idx);
    f   = hash ? (lin ^ (lin >> 4)) : lin;
    s   = 17'(off) + 17'(f);
    v   = '{sel, hash, row, dim, idx, off, value, tag, s[9:0], (s >= 17'd1024) || (sel == 2'd3)};
    return v;
  endfunction

  // Scoreboard: sampled on the falling edge, between driver updates.
  always @(negedge clk) begin
    if (rst) begin
      chk("cen_in_rst", mem_cen, 3'b111);
      exp_q.delete();
      iss_q.delete();
    end else begin
      if (mem_cen != 3'b111) begin
        pulse_cnt++;
        if (iss_q.size() == 0) begin
          chk("cen_unexpected", mem_cen, 3'b111);
        end else begin
          e_iss   = iss_q.pop_front();
          exp_cen = ~(3'b001 << e_iss[11:10]);
          exp_bus = 30'(e_iss[9:0]) << (10 * e_iss[11:10]);
          chk("cen", mem_cen, exp_cen);
          chk("addr", mem_addr, exp_bus);
          chk("wen", mem_wen, 3'b111);
        end
      end
      if (out_valid && out_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          chk("out_unexpected", out_valid, 0);
        end else begin
          e_out = exp_q.pop_front();
          chk("out_err", out_err, e_out[34]);
          chk("out_sel", out_sel, e_out[33:32]);
          chk("out_tag", out_tag, e_out[21:16]);
          chk("out_value", out_value, e_out[15:0]);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({cur_v.exp_err, cur_v.sel, cur_v.exp_addr, cur_v.tag, cur_v.value});
        if (!cur_v.exp_err) iss_q.push_back({cur_v.sel, cur_v.exp_addr});
      end
    end
  end

  task automatic drive(input vec_t v);
    cur_v      = v;
    in_sel     = v.sel;
    in_hash    = v.hash;
    in_row     = v.row;
    in_col_dim = v.col_dim;
    in_col_idx = v.col_idx;
    in_offset  = v.offset;
    in_value   = v.value;
    in_tag     = v.tag;
  endtask

  task automatic send(input vec_t v);
    int t = 0;
    drive(v);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic stream(input int first, input int last, input int max_cyc,
                        output int next, output int cycles);
    int  idx = first;
    int  cyc = 0;
    bit  acc;
    while (idx < last && cyc < max_cyc) begin
      drive(svec[idx]);
      in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    next     = idx;
    cycles   = cyc;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic clear_sticky();
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, cyc, p0, b0, exp_p;

    // sel, hash, row, col_dim, col_idx, offset, value, tag, exp_addr, exp_err
    tbl[0]  = '{2'd0, 1'b0, 6'd3,  10'd100,  10'd7,    10'd16,   16'hA001, 6'd1,  10'd323,  1'b0};
    tbl[1]  = '{2'd2, 1'b1, 6'd0,  10'd5,    10'd341,  10'd0,    16'hB002, 6'd2,  10'd320,  1'b0};
    tbl[2]  = '{2'd1, 1'b0, 6'd0,  10'd0,    10'd50,   10'd1000, 16'hC003, 6'd3,  10'd26,   1'b1};
    tbl[3]  = '{2'd3, 1'b0, 6'd1,  10'd10,   10'd0,    10'd0,    16'hD004, 6'd4,  10'd10,   1'b1};
    tbl[4]  = '{2'd1, 1'b0, 6'd31, 10'd33,   10'd0,    10'd0,    16'hE005, 6'd5,  10'd1023, 1'b0};
    tbl[5]  = '{2'd1, 1'b0, 6'd31, 10'd33,   10'd1,    10'd0,    16'hF006, 6'd6,  10'd0,    1'b1};
    tbl[6]  = '{2'd0, 1'b1, 6'd2,  10'd100,  10'd55,   10'd100,  16'h1007, 6'd7,  10'd340,  1'b0};
    tbl[7]  = '{2'd2, 1'b0, 6'd63, 10'd1023, 10'd1023, 10'd0,    16'h2008, 6'd8,  10'd960,  1'b1};
    tbl[8]  = '{2'd1, 1'b1, 6'd1,  10'd16,   10'd0,    10'd5,    16'h3009, 6'd9,  10'd22,   1'b0};
    tbl[9]  = '{2'd0, 1'b1, 6'd0,  10'd0,    10'd1023, 10'd0,    16'h400A, 6'd10, 10'd960,  1'b0};
    tbl[10] = '{2'd2, 1'b0, 6'd0,  10'd0,    10'd0,    10'd0,    16'h500B, 6'd11, 10'd0,    1'b0};
    for (int i = 0; i < 64; i++) begin
      svec[i] = mk(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                   6'($urandom_range(0, 15)), 10'($urandom_range(0, 60)),
                   10'($urandom_range(0, 100)), 10'($urandom_range(0, 20)),
                   16'($urandom), 6'(i));
    end

    // Clock/reset
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    drive(tbl[0]);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cen", mem_cen, 3'b111);
    chk("rst_wen", mem_wen, 3'b111);
    chk("rst_addr", mem_addr, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_sticky", err_sticky, 0);
    @(posedge clk);
    #1;

    // Latency: accepted at edge N, cen low in N+2, out_valid in N+3
    send(tbl[0]);
    @(negedge clk);
    chk("lat_cen_n1", mem_cen, 3'b111);
    chk("lat_oval_n1", out_valid, 0);
    @(negedge clk);
    chk("lat_cen_n2", mem_cen, 3'b110);
    chk("lat_addr_n2", mem_addr[9:0], 323);
    @(negedge clk);
    chk("lat_oval_n3", out_valid, 1);
    chk("lat_tag_n3", out_tag, 1);
    drain();

    // Vector table, one request at a time
    for (int i = 0; i < 11; i++) begin
      send(tbl[i]);
      drain();
      @(negedge clk);
      chk("vec_sticky", err_sticky, tbl[i].exp_err);
      clear_sticky();
      @(negedge clk);
      chk("vec_sticky_clr", err_sticky, 0);
      @(posedge clk);
      #1;
    end

    // err_clr coinciding with the rejected issue: set must win
    send(tbl[2]);
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    chk("sticky_set_prio", err_sticky, 1);
    drain();
    clear_sticky();

    // Backpressure: 5 requests offered with out_ready low
    exp_p = 0;
    for (int i = 0; i < 5; i++) if (!svec[i].exp_err) exp_p++;
    out_ready = 1'b0;
    p0 = pulse_cnt; b0 = beat_cnt;
    stream(0, 5, 6, idx, cyc);
    chk("bp_accepted", idx, 3);
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_cen_stall", mem_cen, 3'b111);
    chk("bp_pulses", pulse_cnt - p0, svec[0].exp_err ? 0 : 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    stream(idx, 5, 20, idx, cyc);
    drain();
    chk("bp_all_accepted", idx, 5);
    chk("bp_pulses_total", pulse_cnt - p0, exp_p);
    chk("bp_beats", beat_cnt - b0, 5);
    clear_sticky();

    // Reset with S1/S2 full
    stream(5, 7, 10, idx, cyc);
    rst = 1'b1;
    p0 = pulse_cnt; b0 = beat_cnt;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_valid", out_valid, 0);
    repeat (5) @(negedge clk);
    chk("mrst_pulses", pulse_cnt - p0, 0);
    chk("mrst_beats", beat_cnt - b0, 0);
    @(posedge clk);
    #1;

    // Streaming 64 back-to-back
    exp_p = 0;
    for (int i = 0; i < 64; i++) if (!svec[i].exp_err) exp_p++;
    p0 = pulse_cnt; b0 = beat_cnt;
    stream(0, 64, 200, idx, cyc);
    drain();
    chk("strm_accepted", idx, 64);
    chk("strm_cycles", cyc, 64);
    chk("strm_pulses", pulse_cnt - p0, exp_p);
    chk("strm_beats", beat_cnt - b0, 64);

    chk("final_iss_q", iss_q.size(), 0);
    chk("final_exp_q", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
